// File: rtl/arbiter_pkg.sv
// ============================================================================
//  Module  : arbiter_pkg
//  Purpose : Shared constants, width helper and request-vector type macro for
//            the instruction-memory arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

// Request vector type sized by the instantiating module's requester count.
`define ARB_REQ_VEC_T(n) logic [(n)-1:0]

package arbiter_pkg;

   // Cycles from a grant to the matching read word on req_data.
   localparam int c_GRANT_DATA_LAT = 1;

   function automatic int clog2_min1(input int n);
      for (int w = 1; w < 32; w++) begin
         if ((1 << w) >= n) return w;
      end
      return 32;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_encoder.sv
// ============================================================================
//  Module  : rr_priority_encoder
//  Purpose : Combinational round-robin picker: first eligible bit at or after
//            rr_ptr, wrapping, using a double-width masked search.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_priority_encoder
   import arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] elig,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic               any,
   output logic [PTR_W-1:0]   winner_idx,
   output logic [NUM_REQ-1:0] winner_onehot
);

   logic [NUM_REQ-1:0]   w_mask;
   logic [2*NUM_REQ-1:0] w_dbl;
   logic                 w_found;

   // Lower copy keeps only bits at/after rr_ptr; upper copy supplies the wrap.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_mask[i] = (i >= int'(rr_ptr));
      end
      w_dbl = {elig, elig & w_mask};
   end

   always_comb begin
      any           = |elig;
      winner_idx    = '0;
      winner_onehot = '0;
      w_found       = 1'b0;
      for (int i = 0; i < 2*NUM_REQ; i++) begin
         if (!w_found && w_dbl[i]) begin
            w_found    = 1'b1;
            winner_idx = (i >= NUM_REQ) ? PTR_W'(i - NUM_REQ) : PTR_W'(i);
         end
      end
      if (any) winner_onehot = NUM_REQ'(1) << winner_idx;
   end

endmodule

`default_nettype wire

// File: rtl/instr_mem_arbiter.sv
// ============================================================================
//  Module  : instr_mem_arbiter
//  Purpose : Round-robin sharing of one 1-cycle-latency instruction BRAM among
//            NUM_REQ fetch ports. Optional counters under ARB_STATS_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_arbiter
   import arbiter_pkg::*;
#(
   parameter int NUM_REQ           = 4,
   parameter int MEMORY_WIDTH      = 16,
   parameter int MEMORY_ADDR_WIDTH = 11
`ifdef ARB_STATS_EN
   ,
   parameter int STAT_WIDTH        = 32
`endif
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ*MEMORY_ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic [MEMORY_WIDTH-1:0]              req_data,
   output logic [NUM_REQ-1:0]                   req_data_own,
   output logic                                 bram_en,
   output logic [MEMORY_ADDR_WIDTH-1:0]         bram_addr,
   input  logic [MEMORY_WIDTH-1:0]              bram_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]                stat_grants,
   output logic [STAT_WIDTH-1:0]                stat_stalls
`endif
);

   localparam int c_PTR_W = clog2_min1(NUM_REQ);

   logic [c_PTR_W-1:0]           r_rr_ptr;
   `ARB_REQ_VEC_T(NUM_REQ)       r_lockout;
   `ARB_REQ_VEC_T(NUM_REQ)       r_own;
   logic [MEMORY_ADDR_WIDTH-1:0] r_last_addr;

   `ARB_REQ_VEC_T(NUM_REQ)       w_elig;
   `ARB_REQ_VEC_T(NUM_REQ)       w_onehot;
   logic                         w_any;
   logic                         w_grant;
   logic [c_PTR_W-1:0]           w_idx;
   logic [c_PTR_W-1:0]           w_rr_next;

   rr_priority_encoder #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (c_PTR_W)
   ) u_rr_pe (
      .elig          (w_elig),
      .rr_ptr        (r_rr_ptr),
      .any           (w_any),
      .winner_idx    (w_idx),
      .winner_onehot (w_onehot)
   );

   always_comb begin
      w_elig       = req_valid & ~r_lockout;
      w_grant      = w_any & ~reset;
      w_rr_next    = (w_idx == c_PTR_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
      req_ready    = w_grant ? w_onehot : '0;
      bram_en      = w_grant;
      bram_addr    = w_grant ? req_addr[int'(w_idx)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH]
                             : r_last_addr;
      req_data     = bram_rdata;
      // A fetch granted just before reset must not be claimed during reset.
      req_data_own = reset ? '0 : r_own;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr    <= '0;
         r_lockout   <= '0;
         r_own       <= '0;
         r_last_addr <= '0;
      end else if (w_grant) begin
         r_rr_ptr    <= w_rr_next;
         r_lockout   <= w_onehot;
         r_own       <= w_onehot;
         r_last_addr <= bram_addr;
      end else begin
         r_lockout   <= '0;
         r_own       <= '0;
      end
   end

`ifdef ARB_STATS_EN
   logic [STAT_WIDTH-1:0] r_stat_grants;
   logic [STAT_WIDTH-1:0] r_stat_stalls;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_grants <= '0;
         r_stat_stalls <= '0;
      end else begin
         if (w_grant && (r_stat_grants != '1)) r_stat_grants <= r_stat_grants + 1'b1;
         if (($countones(w_elig) > 1) && (r_stat_stalls != '1))
            r_stat_stalls <= r_stat_stalls + 1'b1;
      end
   end

   assign stat_grants = r_stat_grants;
   assign stat_stalls = r_stat_stalls;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_arbiter.sv
// ============================================================================
//  Module  : tb_instr_mem_arbiter
//  Purpose : Directed vector table plus a round-robin order sequence.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_arbiter;
   import arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = 4'b0000;
   logic [43:0] req_addr;
   logic [3:0]  req_ready;
   logic [15:0] req_data;
   logic [3:0]  req_data_own;
   logic        bram_en;
   logic [10:0] bram_addr;
   logic [15:0] bram_rdata = 16'h0000;
`ifdef ARB_STATS_EN
   logic [31:0] stat_grants;
   logic [31:0] stat_stalls;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [10:0] c_A0 = 11'h011;
   localparam logic [10:0] c_A1 = 11'h122;
   localparam logic [10:0] c_A2 = 11'h0CC;
   localparam logic [10:0] c_A3 = 11'h7FF;

   assign req_addr = {c_A3, c_A2, c_A1, c_A0};

   instr_mem_arbiter #(
      .NUM_REQ           (4),
      .MEMORY_WIDTH      (16),
      .MEMORY_ADDR_WIDTH (11)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_ready    (req_ready),
      .req_data     (req_data),
      .req_data_own (req_data_own),
      .bram_en      (bram_en),
      .bram_addr    (bram_addr),
      .bram_rdata   (bram_rdata)
`ifdef ARB_STATS_EN
      ,
      .stat_grants  (stat_grants),
      .stat_stalls  (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [10:0] a);
      return {5'b10101, a};
   endfunction

   // Behavioural BRAM with one cycle of read latency.
   always @(posedge clk) begin
      if (bram_en) bram_rdata <= mem_word(bram_addr);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  ready;
      logic        en;
      logic        chk_addr;
      logic [10:0] addr;
      logic [3:0]  own;
      logic [10:0] daddr;
      int          grants;
      int          stalls;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [3:0] valid, input logic [3:0] ready,
                      input logic en, input logic chk_addr, input logic [10:0] addr,
                      input logic [3:0] own, input logic [10:0] daddr,
                      input int grants, input int stalls);
      vec_t v;
      v.rst = rst; v.valid = valid; v.ready = ready; v.en = en; v.chk_addr = chk_addr;
      v.addr = addr; v.own = own; v.daddr = daddr; v.grants = grants; v.stalls = stalls;
      vecs.push_back(v);
   endtask

   initial begin
      logic [3:0] prev_ready;
      int         exp_order[9];
      int         wait_cnt[4];
      int         max_wait;

      // reset held with all requesters active
      add(1, 4'hF, 4'h0, 0, 0, 11'h000, 4'h0, 11'h000, 0, 0);
      add(1, 4'hF, 4'h0, 0, 0, 11'h000, 4'h0, 11'h000, 0, 0);
      // fairness: 0,1,2,3,0,1,2,3
      add(0, 4'hF, 4'h1, 1, 1, c_A0, 4'h0, 11'h000, 0, 0);
      add(0, 4'hF, 4'h2, 1, 1, c_A1, 4'h1, c_A0,    1, 1);
      add(0, 4'hF, 4'h4, 1, 1, c_A2, 4'h2, c_A1,    2, 2);
      add(0, 4'hF, 4'h8, 1, 1, c_A3, 4'h4, c_A2,    3, 3);
      add(0, 4'hF, 4'h1, 1, 1, c_A0, 4'h8, c_A3,    4, 4);
      add(0, 4'hF, 4'h2, 1, 1, c_A1, 4'h1, c_A0,    5, 5);
      add(0, 4'hF, 4'h4, 1, 1, c_A2, 4'h2, c_A1,    6, 6);
      add(0, 4'hF, 4'h8, 1, 1, c_A3, 4'h4, c_A2,    7, 7);
      // wrap and skip with 4'b1010
      add(0, 4'hA, 4'h2, 1, 1, c_A1, 4'h8, c_A3,    8, 8);
      add(0, 4'hA, 4'h8, 1, 1, c_A3, 4'h2, c_A1,    9, 8);
      add(0, 4'hA, 4'h2, 1, 1, c_A1, 4'h8, c_A3,   10, 8);
      add(0, 4'hA, 4'h8, 1, 1, c_A3, 4'h2, c_A1,   11, 8);
      // idle: address holds
      add(0, 4'h0, 4'h0, 0, 1, c_A3, 4'h8, c_A3,   12, 8);
      // single persistent requester: every other cycle
      add(0, 4'h1, 4'h1, 1, 1, c_A0, 4'h0, 11'h000, 12, 8);
      add(0, 4'h1, 4'h0, 0, 1, c_A0, 4'h1, c_A0,    13, 8);
      add(0, 4'h1, 4'h1, 1, 1, c_A0, 4'h0, 11'h000, 13, 8);
      add(0, 4'h1, 4'h0, 0, 1, c_A0, 4'h1, c_A0,    14, 8);
      add(0, 4'h1, 4'h1, 1, 1, c_A0, 4'h0, 11'h000, 14, 8);
      add(0, 4'h1, 4'h0, 0, 1, c_A0, 4'h1, c_A0,    15, 8);
      // single fetch from requester 2
      add(0, 4'h4, 4'h4, 1, 1, c_A2, 4'h0, 11'h000, 15, 8);
      add(0, 4'h4, 4'h0, 0, 1, c_A2, 4'h4, c_A2,    16, 8);
      // reset mid-fetch
      add(0, 4'h2, 4'h2, 1, 1, c_A1, 4'h0, 11'h000, 16, 8);
      add(1, 4'h2, 4'h0, 0, 0, 11'h000, 4'h0, 11'h000, 17, 8);
      add(0, 4'h2, 4'h2, 1, 1, c_A1, 4'h0, 11'h000, 0, 0);
      add(0, 4'h0, 4'h0, 0, 1, c_A1, 4'h2, c_A1,    1, 0);

      foreach (vecs[k]) begin
         @(posedge clk);
         #1;
         reset     = vecs[k].rst;
         req_valid = vecs[k].valid;
         @(negedge clk);
         check($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(vecs[k].ready));
         check($sformatf("v%0d bram_en", k), 32'(bram_en), 32'(vecs[k].en));
         check($sformatf("v%0d req_data_own", k), 32'(req_data_own), 32'(vecs[k].own));
         if (vecs[k].chk_addr)
            check($sformatf("v%0d bram_addr", k), 32'(bram_addr), 32'(vecs[k].addr));
         if (vecs[k].own != 4'h0)
            check($sformatf("v%0d req_data", k), 32'(req_data), 32'(mem_word(vecs[k].daddr)));
`ifdef ARB_STATS_EN
         check($sformatf("v%0d stat_grants", k), stat_grants, vecs[k].grants);
         check($sformatf("v%0d stat_stalls", k), stat_stalls, vecs[k].stalls);
`endif
      end

      // rr_ptr is 2 here; 4'b1011 held must rotate 3,0,1 with no starvation.
      exp_order = '{3, 0, 1, 3, 0, 1, 3, 0, 1};
      prev_ready = 4'h0;
      wait_cnt = '{0, 0, 0, 0};
      max_wait = 0;
      for (int c = 0; c < 9; c++) begin
         @(posedge clk);
         #1;
         req_valid = 4'b1011;
         @(negedge clk);
         check($sformatf("rr%0d grant", c), 32'(req_ready), 32'(4'h1 << exp_order[c]));
         check($sformatf("rr%0d no_repeat", c), 32'(req_ready == prev_ready && req_ready != 0), 32'(0));
         if (c > 0)
            check($sformatf("rr%0d data_own", c), 32'(req_data_own), 32'(4'h1 << exp_order[c-1]));
         for (int r = 0; r < 4; r++) begin
            if (req_valid[r] && !req_ready[r]) wait_cnt[r]++;
            else wait_cnt[r] = 0;
            if (wait_cnt[r] > max_wait) max_wait = wait_cnt[r];
         end
         prev_ready = req_ready;
      end
      check("rr max_wait_below_num_req", 32'(max_wait < 4), 32'(1));
      check("grant_data_latency", 32'(c_GRANT_DATA_LAT), 32'(1 + 0 * max_wait));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
